// File: rtl/reset_sequencer.sv
// Reset sequencer for the game logic and display pipeline.
// All reset channels assert together. Once the reset source goes away
// they stay asserted for HOLD_CYCLES edges, then release one at a time
// (bit 0 first), GAP_CYCLES edges apart. A restart comes from the
// synchronised, debounced board button or from a single-cycle soft
// request. A held button stretches the reset until it is let go.
module reset_sequencer #(
  parameter int CHANNELS        = 3,
  parameter int HOLD_CYCLES     = 50000000,
  parameter int GAP_CYCLES      = 1000,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SYNC_STAGES     = 2,
  parameter int OUT_ACTIVE_HIGH = 1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                req_n,
  input  logic                soft_req,
  output logic [CHANNELS-1:0] reset_out,
  output logic                busy,
  output logic [3:0]          stage
);

  // One counter width covers the hold, gap and debounce counts.
  localparam int MAX_HG  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int MAX_ALL = (MAX_HG > DEBOUNCE_CYCLES) ? MAX_HG : DEBOUNCE_CYCLES;
  localparam int CNT_W   = $clog2(MAX_ALL + 1);

  // A counter "reaches" N on the edge where it would step from N-1 to N.
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic       ACT_LVL    = (OUT_ACTIVE_HIGH != 0) ? 1'b1 : 1'b0;
  localparam logic       INACT_LVL  = ~ACT_LVL;
  localparam logic [3:0] ALL_STAGES = 4'(CHANNELS);
  localparam logic [3:0] LAST_STAGE = 4'(CHANNELS - 1);

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_STAGGER = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sampled_s;
  logic                   deb_r;
  logic [CNT_W-1:0]       deb_cnt_r;
  logic                   deb_fall_s;
  logic                   restart_s;

  state_t                 state_r;
  logic [CNT_W-1:0]       cnt_r;
  logic [3:0]             stage_r;
  logic                   busy_r;
  logic [CHANNELS-1:0]    out_r;

  // Bring the asynchronous button into the clock domain; idle level is 1.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_r <= {SYNC_STAGES{1'b1}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], req_n};
    end
  end

  assign sampled_s = sync_r[SYNC_STAGES-1];

  // Debounce: the level flips only after DEBOUNCE_CYCLES differing samples in a row.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      deb_r     <= 1'b1;
      deb_cnt_r <= '0;
    end else if (sampled_s == deb_r) begin
      deb_cnt_r <= '0;
    end else if (deb_cnt_r == DEB_LAST) begin
      deb_r     <= sampled_s;
      deb_cnt_r <= '0;
    end else begin
      deb_cnt_r <= deb_cnt_r + 1'b1;
    end
  end

  // A press is recognised on the very edge the debounced level falls, so the
  // restart lands together with the level change rather than one edge later.
  assign deb_fall_s = deb_r & ~sampled_s & (deb_cnt_r == DEB_LAST);
  assign restart_s  = soft_req | deb_fall_s;

  // Sequencer: hold all channels, then stagger releases, then run.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_HOLD;
      cnt_r   <= '0;
      stage_r <= 4'd0;
      busy_r  <= 1'b1;
      out_r   <= {CHANNELS{ACT_LVL}};
    end else if (restart_s) begin
      // A restart beats any release scheduled on the same edge.
      state_r <= ST_HOLD;
      cnt_r   <= '0;
      stage_r <= 4'd0;
      busy_r  <= 1'b1;
      out_r   <= {CHANNELS{ACT_LVL}};
    end else begin
      case (state_r)
        ST_HOLD: begin
          if (!deb_r) begin
            // Button still held: stretch the reset.
            cnt_r <= '0;
          end else if (cnt_r == HOLD_LAST) begin
            cnt_r    <= '0;
            out_r[0] <= INACT_LVL;
            stage_r  <= 4'd1;
            if (CHANNELS == 1) begin
              state_r <= ST_RUN;
              busy_r  <= 1'b0;
            end else begin
              state_r <= ST_STAGGER;
            end
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        ST_STAGGER: begin
          if (cnt_r == GAP_LAST) begin
            cnt_r <= '0;
            // stage_r is the index of the next channel to release.
            for (int i = 0; i < CHANNELS; i++) begin
              if (i == int'(stage_r)) begin
                out_r[i] <= INACT_LVL;
              end else begin
                out_r[i] <= out_r[i];
              end
            end
            stage_r <= stage_r + 4'd1;
            if (stage_r == LAST_STAGE) begin
              state_r <= ST_RUN;
              busy_r  <= 1'b0;
            end else begin
              state_r <= ST_STAGGER;
            end
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        ST_RUN: begin
          cnt_r   <= '0;
          stage_r <= ALL_STAGES;
          busy_r  <= 1'b0;
          out_r   <= {CHANNELS{INACT_LVL}};
        end
        default: begin
          state_r <= ST_HOLD;
          cnt_r   <= '0;
          stage_r <= 4'd0;
          busy_r  <= 1'b1;
          out_r   <= {CHANNELS{ACT_LVL}};
        end
      endcase
    end
  end

  assign reset_out = out_r;
  assign busy      = busy_r;
  assign stage     = stage_r;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer. Expected output snapshots are
// queued with the edge they are due on; each clock step pops and compares
// the entries that have come due.
module tb_reset_sequencer;

  localparam int HOLD = 10;
  localparam int GAP  = 4;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       req_n;
  logic       soft_req;
  logic [2:0] reset_out0;
  logic       busy0;
  logic [3:0] stage0;
  logic [0:0] reset_out1;
  logic       busy1;
  logic [3:0] stage1;

  int checks   = 0;
  int failures = 0;
  int edge_n   = 0;

  typedef struct {
    int         cyc;
    int         sel;
    logic [2:0] out;
    logic       busy;
    logic [3:0] stg;
    string      name;
  } exp_t;

  exp_t exp_q[$];

  always #5 clock = ~clock;

  reset_sequencer #(
    .CHANNELS(3), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP),
    .DEBOUNCE_CYCLES(5), .SYNC_STAGES(2), .OUT_ACTIVE_HIGH(1)
  ) u_dut0 (
    .clock(clock), .reset_n(reset_n), .req_n(req_n), .soft_req(soft_req),
    .reset_out(reset_out0), .busy(busy0), .stage(stage0)
  );

  reset_sequencer #(
    .CHANNELS(1), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP),
    .DEBOUNCE_CYCLES(5), .SYNC_STAGES(2), .OUT_ACTIVE_HIGH(0)
  ) u_dut1 (
    .clock(clock), .reset_n(reset_n), .req_n(req_n), .soft_req(soft_req),
    .reset_out(reset_out1), .busy(busy1), .stage(stage1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic push(input int cyc, input int sel, input logic [2:0] o,
                      input logic b, input logic [3:0] s, input string nm);
    exp_t e;
    e.cyc = cyc; e.sel = sel; e.out = o; e.busy = b; e.stg = s; e.name = nm;
    exp_q.push_back(e);
  endtask

  // Standard 3-channel release schedule counted from edge 'base'.
  task automatic push_sched(input int base, input string nm);
    push(base + HOLD - 1,           0, 3'b111, 1'b1, 4'd0, nm);
    push(base + HOLD,               0, 3'b110, 1'b1, 4'd1, nm);
    push(base + HOLD + GAP - 1,     0, 3'b110, 1'b1, 4'd1, nm);
    push(base + HOLD + GAP,         0, 3'b100, 1'b1, 4'd2, nm);
    push(base + HOLD + 2 * GAP - 1, 0, 3'b100, 1'b1, 4'd2, nm);
    push(base + HOLD + 2 * GAP,     0, 3'b000, 1'b0, 4'd3, nm);
    push(base + HOLD + 2 * GAP + 3, 0, 3'b000, 1'b0, 4'd3, nm);
  endtask

  task automatic compare_entry(input exp_t e);
    string t;
    t = $sformatf("%s@%0d", e.name, e.cyc);
    if (e.sel == 0) begin
      check({t, "_out"},   32'(reset_out0), 32'(e.out));
      check({t, "_busy"},  32'(busy0),      32'(e.busy));
      check({t, "_stage"}, 32'(stage0),     32'(e.stg));
    end else begin
      check({t, "_out1"},   32'(reset_out1), 32'(e.out[0]));
      check({t, "_busy1"},  32'(busy1),      32'(e.busy));
      check({t, "_stage1"}, 32'(stage1),     32'(e.stg));
    end
  endtask

  // Advance one edge and compare every expectation due on it.
  task automatic step();
    @(posedge clock);
    #1;
    edge_n++;
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].cyc == edge_n) begin
        compare_entry(exp_q[i]);
        exp_q.delete(i);
      end
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic raise_reset();
    @(negedge clock);
    reset_n = 1'b1;
    edge_n  = 0;
  endtask

  initial begin
    reset_n  = 1'b0;
    req_n    = 1'b1;
    soft_req = 1'b0;
    #23;
    // Scenario 1 / 6: reset state and power-on release timing
    check("rst_out0",   32'(reset_out0), 32'h7);
    check("rst_busy0",  32'(busy0),      32'h1);
    check("rst_stage0", 32'(stage0),     32'h0);
    check("rst_out1",   32'(reset_out1), 32'h0);
    check("rst_busy1",  32'(busy1),      32'h1);
    raise_reset();
    push_sched(0, "pwr");
    push(HOLD - 1, 1, 3'b000, 1'b1, 4'd0, "ch1");
    push(HOLD,     1, 3'b001, 1'b0, 4'd1, "ch1");
    push(HOLD + 1, 1, 3'b001, 1'b0, 4'd1, "ch1");
    steps(22);
    check("pwr_drain", 32'(exp_q.size()), 32'h0);

    // Scenario 2: asynchronous reset in the middle of a sequence
    reset_n = 1'b0;
    #12;
    raise_reset();
    push(HOLD - 1,   0, 3'b111, 1'b1, 4'd0, "mid");
    push(HOLD,       0, 3'b110, 1'b1, 4'd1, "mid");
    push(HOLD + GAP, 0, 3'b100, 1'b1, 4'd2, "mid");
    push(15,         0, 3'b100, 1'b1, 4'd2, "mid");
    steps(15);
    reset_n = 1'b0;
    #2;
    check("async_out",   32'(reset_out0), 32'h7);
    check("async_busy",  32'(busy0),      32'h1);
    check("async_stage", 32'(stage0),     32'h0);
    #10;
    raise_reset();
    push_sched(0, "rerise");
    steps(22);
    check("rerise_drain", 32'(exp_q.size()), 32'h0);

    // Scenario 3a: short bounces never reach the debounce count
    edge_n = 0;
    for (int e = 1; e <= 20; e++) push(e, 0, 3'b000, 1'b0, 4'd3, "bounce");
    for (int i = 0; i < 20; i++) begin
      req_n = (i < 3) ? 1'b0 : (i < 5) ? 1'b1 : (i < 8) ? 1'b0 : 1'b1;
      step();
    end
    check("bounce_drain", 32'(exp_q.size()), 32'h0);

    // Scenario 3b: long press stretches reset, release restarts timing
    edge_n = 0;
    req_n  = 1'b0;
    push(5, 0, 3'b000, 1'b0, 4'd3, "press");
    for (int e = 8; e <= 60; e++) push(e, 0, 3'b111, 1'b1, 4'd0, "press");
    steps(60);
    req_n = 1'b1;
    for (int e = 61; e <= 75; e++) push(e, 0, 3'b111, 1'b1, 4'd0, "hold");
    push(79, 0, 3'b110, 1'b1, 4'd1, "unpress");
    push(83, 0, 3'b100, 1'b1, 4'd2, "unpress");
    for (int e = 87; e <= 90; e++) push(e, 0, 3'b000, 1'b0, 4'd3, "unpress");
    steps(30);
    check("press_drain", 32'(exp_q.size()), 32'h0);

    // Scenario 4: soft request from RUN
    edge_n   = 0;
    soft_req = 1'b1;
    push(1, 0, 3'b111, 1'b1, 4'd0, "soft");
    push_sched(1, "soft");
    step();
    soft_req = 1'b0;
    steps(21);
    check("soft_drain", 32'(exp_q.size()), 32'h0);

    // Scenario 5: soft request on the edge channel 1 is due
    edge_n   = 0;
    soft_req = 1'b1;
    push(1 + HOLD,       0, 3'b110, 1'b1, 4'd1, "race");
    push(HOLD + GAP,     0, 3'b110, 1'b1, 4'd1, "race");
    push(1 + HOLD + GAP, 0, 3'b111, 1'b1, 4'd0, "race");
    push(5 + HOLD + GAP, 0, 3'b111, 1'b1, 4'd0, "race");
    push_sched(1 + HOLD + GAP, "race");
    step();
    soft_req = 1'b0;
    steps(HOLD + GAP - 1);
    soft_req = 1'b1;
    step();
    soft_req = 1'b0;
    steps(21);
    check("race_drain", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
